cpu65_bus_bridge: RTL
=====================

Name: cpu65_bus_bridge

Overview:
- Parametrised 65xx-family bus bridge between a gate-level 65xx core (6502/6507-class, any address width) and a synchronous, variable-latency memory port.
- Derives the core's clk0 from eclk and generates the core's reset sequence.
- Converts each phi2 bus cycle into a memory req/ack transaction.
- Stretches clk0 high until memory completes, so one bridge serves cores of any address width and memories of any latency.

Parameters:
- ADDR_W, 13, core/memory address width (13 = 6507, 16 = 6502).
- HALF_DIV, 4, eclk cycles per clk0 half-phase; legal ≥2.
- WR_SETUP, 1, eclk offset into phi2 at which write data is sampled and the write request issued; legal 0..HALF_DIV-1.
- RESET_HOLD, 8, completed phi cycles that cpu_res stays low after reset release; legal ≥1.
- TIMEOUT, 64, eclk cycles of stretch before forced completion; used only with the optional feature.

Ports:
- eclk  in  1  system clock.
- ereset  in  1  synchronous reset, active-low: asserted when 0, sampled on the eclk rising edge.
- clk0  out  1  generated phase clock to the core.
- cpu_res  out  1  core reset, active-low.
- cpu_ab  in  ADDR_W  core address bus.
- cpu_rw  in  1  core read/write; 1 = read.
- cpu_db_o  in  8  core write data.
- cpu_db_i  out  8  read data to the core.
- mem_req  out  1  memory request, level.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  8  request write data.
- mem_ack  in  1  single-cycle completion.
- mem_rdata  in  8  read data, valid with mem_ack.
- phi_cnt  out  16  completed phi cycles, wraps.
- stretch  out  1  high while clk0 is being held high awaiting ack.
- bus_err  out  1  timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset values while ereset=0:
  - clk0=0, cpu_res=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_db_i=8'h00, phi_cnt=0, stretch=0, bus_err=0.
  - Divider count=0, state=PHI1, reset-hold counter=0.
- Divider: counts 0..HALF_DIV-1 and wraps. The terminal count (TC) is HALF_DIV-1.
- State PHI1 (clk0=0):
  - At TC: clk0<=1, latch cpu_ab->mem_addr and cpu_rw->mem_we, go to PHI2_WAIT.
  - If read: mem_req<=1 on the same edge.
- State PHI2_WAIT (clk0=1):
  - If write, at count==WR_SETUP: latch cpu_db_o->mem_wdata and set mem_req<=1.
  - mem_ack is honoured only while mem_req=1; otherwise it is ignored.
  - On honoured ack: mem_req<=0. If read, cpu_db_i<=mem_rdata. Go to PHI2_DONE.
  - If TC is reached with no ack: divider holds at TC, clk0 stays 1, stretch=1.
- State PHI2_DONE:
  - At TC, or on the edge after ack if already stretching: clk0<=0, stretch<=0, phi_cnt<=phi_cnt+1 (mod 2^16), divider<=0, go to PHI1.
- Ack timing:
  - Ack on the same edge that mem_req rises is impossible, because req is registered.
  - Ack ≥1 cycle later is legal.
  - Ack arriving at TC completes without stretch; clk0 falls on the next TC (normal timing).
- cpu_db_i holds its last read value across writes and across phi1.
- cpu_res:
  - Counts completed phi cycles after ereset release.
  - Goes 1 on the edge where the count reaches RESET_HOLD, then stays 1 until the next ereset.
  - The bridge still performs bus cycles while cpu_res=0.
- Reset mid-transaction: all state returns to reset values on the next edge; the outstanding ack is ignored.
- Unstretched phi period is 2*HALF_DIV eclk.

Optional Feature:
- Macro: CPU65_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A stretch counter counts eclk cycles while stretch=1.
  - On reaching TIMEOUT: mem_req<=0, bus_err pulses 1 for one cycle, and the cycle completes as if acked.
  - On read timeout, cpu_db_i<=8'hFF; on write timeout, the write is dropped.
  - A late ack is ignored.
- Without the macro: stretching is unbounded and bus_err is constant 0.

Decomposition:
- Package cpu65_bridge_pkg holds:
  - State enum {PHI1, PHI2_WAIT, PHI2_DONE}.
  - Constants DB_W=8, PHI_CNT_W=16, TIMEOUT_RDATA=8'hFF.
- Sub-module cpu65_phase_gen holds the divider, the clk0 register and the hold-at-TC stretch input. It exports tc and count.

Test Plan:
- Reset, then no ack, defaults: clk0 toggles every 4 eclk until the first stretch; cpu_res rises after 8 completed phi cycles with immediate-ack memory; all outputs hold reset values while ereset=0.
- Read 0x1FFC, memory acks 1 cycle after req with 8'hA5: mem_we=0, mem_addr=0x1FFC, cpu_db_i=8'hA5 at ack+1, no stretch, phi period 8 eclk.
- Write 0x0080 data 8'h3C, WR_SETUP=1: mem_req rises 1 cycle into phi2 with mem_wdata=8'h3C and mem_we=1; cpu_db_i unchanged.
- Ack delayed 10 cycles: clk0 high for 11 eclk, stretch=1 for 7 cycles, phi_cnt increments once.
- ereset=0 mid-PHI2_WAIT, then ack during reset: mem_req=0 next edge, cpu_db_i=8'h00, ack ignored.
- With CPU65_BRIDGE_TIMEOUT_EN, TIMEOUT=64, read never acked: bus_err single pulse, cpu_db_i=8'hFF, clk0 falls next edge; a late ack is ignored.

Source files
------------

// File: rtl/cpu65_bridge_pkg.sv
// Shared types and constants for the 65xx core to memory bus bridge.
//   phi_state_e   : bus-cycle sequencer states
//   DB_W          : core data bus width
//   PHI_CNT_W     : width of the completed-phi-cycle counter
//   TIMEOUT_RDATA : read data returned to the core when memory never answers
package cpu65_bridge_pkg;

  typedef enum logic [1:0] {
    PHI1      = 2'd0,
    PHI2_WAIT = 2'd1,
    PHI2_DONE = 2'd2
  } phi_state_e;

  localparam int          DB_W          = 8;
  localparam int          PHI_CNT_W     = 16;
  localparam logic [7:0]  TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/cpu65_phase_gen.sv
// Half-phase divider and clk0 register for the 65xx bus bridge.
//   eclk, ereset : system clock, synchronous active-low reset
//   hold         : freeze the divider while it sits at terminal count
//   clk0_set     : drive clk0 high on this edge (start of phi2)
//   clk0_clr     : drive clk0 low on this edge (end of phi2)
//   tc           : divider is at terminal count (HALF_DIV-1)
//   count        : current divider value
//   clk0         : registered phase clock to the core
module cpu65_phase_gen #(
  parameter int HALF_DIV = 4,
  parameter int CNT_W    = $clog2(HALF_DIV)
) (
  input  logic             eclk,
  input  logic             ereset,
  input  logic             hold,
  input  logic             clk0_set,
  input  logic             clk0_clr,
  output logic             tc,
  output logic [CNT_W-1:0] count,
  output logic             clk0
);

  assign tc = (count == CNT_W'(HALF_DIV - 1));

  // Completion of phi2 always happens at TC, so the natural wrap doubles
  // as the divider restart when a stretched cycle finally ends.
  always_ff @(posedge eclk) begin
    if (!ereset) begin
      count <= '0;
      clk0  <= 1'b0;
    end else begin
      if (!(hold && tc))
        count <= tc ? '0 : count + CNT_W'(1);
      if (clk0_clr)
        clk0 <= 1'b0;
      else if (clk0_set)
        clk0 <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu65_bus_bridge.sv
// Bridge between a gate-level 65xx core and a synchronous variable-latency
// memory port. Generates clk0 and the core reset, turns each phi2 into a
// req/ack transaction, and stretches clk0 high until memory answers.
//
// Optional feature: define CPU65_BRIDGE_TIMEOUT_EN to bound the stretch to
// TIMEOUT eclk cycles, after which the cycle is force-completed with a
// bus_err pulse (reads return TIMEOUT_RDATA, writes are dropped).
//
// Ports:
//   eclk, ereset          : system clock, synchronous active-low reset
//   clk0, cpu_res         : phase clock and active-low reset to the core
//   cpu_ab/cpu_rw/cpu_db_o: core address, read(1)/write(0), write data
//   cpu_db_i              : read data returned to the core
//   mem_req/we/addr/wdata : level request to memory
//   mem_ack/mem_rdata     : single-cycle completion and read data
//   phi_cnt               : completed phi cycles (wraps)
//   stretch               : clk0 being held high awaiting ack
//   bus_err               : timeout pulse (0 without the optional feature)
module cpu65_bus_bridge
  import cpu65_bridge_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int HALF_DIV   = 4,
  parameter int WR_SETUP   = 1,
  parameter int RESET_HOLD = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                 eclk,
  input  logic                 ereset,
  output logic                 clk0,
  output logic                 cpu_res,
  input  logic [ADDR_W-1:0]    cpu_ab,
  input  logic                 cpu_rw,
  input  logic [DB_W-1:0]      cpu_db_o,
  output logic [DB_W-1:0]      cpu_db_i,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DB_W-1:0]      mem_wdata,
  input  logic                 mem_ack,
  input  logic [DB_W-1:0]      mem_rdata,
  output logic [PHI_CNT_W-1:0] phi_cnt,
  output logic                 stretch,
  output logic                 bus_err
);

  localparam int CNT_W = $clog2(HALF_DIV);
  localparam int RH_W  = $clog2(RESET_HOLD + 1);

  if (HALF_DIV < 2 || WR_SETUP < 0 || WR_SETUP >= HALF_DIV ||
      RESET_HOLD < 1 || TIMEOUT < 1) begin : g_param_err
    $error("cpu65_bus_bridge: illegal parameter combination");
  end

  phi_state_e       state, state_nxt;
  logic             tc, clk0_set, clk0_clr, div_hold;
  logic [CNT_W-1:0] div_cnt;
  logic [RH_W-1:0]  rst_cnt;
  logic             ack_ok, wr_issue, tmo_hit;

  cpu65_phase_gen #(
    .HALF_DIV (HALF_DIV),
    .CNT_W    (CNT_W)
  ) u_phase (
    .eclk     (eclk),
    .ereset   (ereset),
    .hold     (div_hold),
    .clk0_set (clk0_set),
    .clk0_clr (clk0_clr),
    .tc       (tc),
    .count    (div_cnt),
    .clk0     (clk0)
  );

  // An ack only counts against an outstanding request; req is registered,
  // so an ack on the same edge req rises is never seen.
  assign ack_ok   = (state == PHI2_WAIT) && mem_req && mem_ack;
  // !mem_req keeps a write from re-issuing while the divider is held at TC
  // when WR_SETUP sits on the terminal count.
  assign wr_issue = (state == PHI2_WAIT) && mem_we && !mem_req &&
                    (div_cnt == CNT_W'(WR_SETUP));
  // clk0 may not fall before the transaction resolves.
  assign div_hold = (state == PHI2_WAIT);

`ifdef CPU65_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             bus_err_q;

  assign tmo_hit = stretch && (state == PHI2_WAIT) && !ack_ok &&
                   (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge eclk) begin
    if (!ereset) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= tmo_hit;
      tmo_cnt   <= (stretch && state == PHI2_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge eclk) begin
    if (!ereset) state <= PHI1;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clk0_set  = 1'b0;
    clk0_clr  = 1'b0;
    case (state)
      PHI1: if (tc) begin
        state_nxt = PHI2_WAIT;
        clk0_set  = 1'b1;
      end
      PHI2_WAIT: if (ack_ok || tmo_hit)
        state_nxt = PHI2_DONE;
      PHI2_DONE: if (tc) begin
        state_nxt = PHI1;
        clk0_clr  = 1'b1;
      end
      default: state_nxt = PHI1;
    endcase
  end

  always_ff @(posedge eclk) begin
    if (!ereset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_db_i  <= '0;
      phi_cnt   <= '0;
      stretch   <= 1'b0;
      cpu_res   <= 1'b0;
      rst_cnt   <= '0;
    end else begin
      case (state)
        PHI1: if (tc) begin
          mem_addr <= cpu_ab;
          mem_we   <= ~cpu_rw;
          mem_req  <= cpu_rw;          // reads request on the clk0 rising edge
        end
        PHI2_WAIT: begin
          if (wr_issue) begin
            mem_wdata <= cpu_db_o;
            mem_req   <= 1'b1;
          end
          if (ack_ok) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_db_i <= mem_rdata;
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_db_i <= TIMEOUT_RDATA;
          end else if (tc) begin
            stretch <= 1'b1;
          end
        end
        PHI2_DONE: if (tc) begin
          stretch <= 1'b0;
          phi_cnt <= phi_cnt + PHI_CNT_W'(1);
          if (!cpu_res) begin
            rst_cnt <= rst_cnt + RH_W'(1);
            if (rst_cnt == RH_W'(RESET_HOLD - 1)) cpu_res <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
